// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - RV32I opcodes, funct3 codes and ALU operation encoding
// Shared decode constants for the ID stage and any other unit that needs to
// recognise instruction classes. No ports.
package riscv_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [2:0] F3_ADD_SUB = 3'd0;
  localparam logic [2:0] F3_SLL     = 3'd1;
  localparam logic [2:0] F3_SLT     = 3'd2;
  localparam logic [2:0] F3_SLTU    = 3'd3;
  localparam logic [2:0] F3_XOR     = 3'd4;
  localparam logic [2:0] F3_SRL_SRA = 3'd5;
  localparam logic [2:0] F3_OR      = 3'd6;
  localparam logic [2:0] F3_AND     = 3'd7;

  typedef enum logic [3:0] {
    ALU_ADD    = 4'd0,
    ALU_SUB    = 4'd1,
    ALU_SLL    = 4'd2,
    ALU_SLT    = 4'd3,
    ALU_SLTU   = 4'd4,
    ALU_XOR    = 4'd5,
    ALU_SRL    = 4'd6,
    ALU_SRA    = 4'd7,
    ALU_OR     = 4'd8,
    ALU_AND    = 4'd9,
    ALU_PASS_B = 4'd10
  } alu_op_t;

  // Arithmetic op for OP / OP-IMM. alt is funct7[5]; it only matters for
  // ADD/SUB and SRL/SRA, the caller decides when it may be honoured.
  function automatic alu_op_t alu_arith(input logic [2:0] f3, input logic alt);
    alu_op_t op;
    case (f3)
      F3_ADD_SUB: op = alt ? ALU_SUB : ALU_ADD;
      F3_SLL:     op = ALU_SLL;
      F3_SLT:     op = ALU_SLT;
      F3_SLTU:    op = ALU_SLTU;
      F3_XOR:     op = ALU_XOR;
      F3_SRL_SRA: op = alt ? ALU_SRA : ALU_SRL;
      F3_OR:      op = ALU_OR;
      default:    op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/imm_gen.sv
// rtl/imm_gen.sv - sign-extended immediate generator for RV32I formats
// Purely combinational; also used by the IF branch predictor.
// Ports: instr (32-bit instruction word) -> imm (XLEN-bit sign-extended immediate).
module imm_gen
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr,
  output logic [XLEN-1:0] imm
);

  logic [31:0] imm32;

  always_comb begin
    imm32 = 32'd0;
    case (instr[6:0])
      OPC_LUI, OPC_AUIPC:             imm32 = {instr[31:12], 12'd0};
      OPC_JAL:                        imm32 = {{11{instr[31]}}, instr[31], instr[19:12],
                                               instr[20], instr[30:21], 1'b0};
      OPC_JALR, OPC_LOAD, OPC_OP_IMM: imm32 = {{20{instr[31]}}, instr[31:20]};
      OPC_STORE:                      imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      OPC_BRANCH:                     imm32 = {{19{instr[31]}}, instr[31], instr[7],
                                               instr[30:25], instr[11:8], 1'b0};
      default:                        imm32 = 32'd0;
    endcase
  end

  // Replication count is XLEN-31 so it stays legal when XLEN == 32.
  assign imm = {{(XLEN-31){imm32[31]}}, imm32[30:0]};

endmodule

// File: rtl/id_stage.sv
// rtl/id_stage.sv - RV32I decode stage with load-use hazard detect and ID/EX register
// Ports: clock/reset (sync, active-low); IF/ID side if_valid, if_instr, if_pc,
// id_ready; register file rf_read_address_1/2, rf_data_1/2; EX side ex_stall,
// ex_flush and the latched ID/EX fields ex_*.
module id_stage
  import riscv_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            if_valid,
  input  logic [31:0]     if_instr,
  input  logic [XLEN-1:0] if_pc,
  output logic            id_ready,
  output logic [4:0]      rf_read_address_1,
  output logic [4:0]      rf_read_address_2,
  input  logic [XLEN-1:0] rf_data_1,
  input  logic [XLEN-1:0] rf_data_2,
  input  logic            ex_stall,
  input  logic            ex_flush,
  output logic            ex_valid,
  output logic [XLEN-1:0] ex_pc,
  output logic [XLEN-1:0] ex_rs1_data,
  output logic [XLEN-1:0] ex_rs2_data,
  output logic [XLEN-1:0] ex_imm,
  output logic [4:0]      ex_rs1,
  output logic [4:0]      ex_rs2,
  output logic [4:0]      ex_rd,
  output logic [2:0]      ex_funct3,
  output logic [3:0]      ex_alu_op,
  output logic            ex_alu_src_imm,
  output logic            ex_alu_src_pc,
  output logic            ex_mem_read,
  output logic            ex_mem_write,
  output logic            ex_reg_write,
  output logic            ex_branch,
  output logic            ex_jump,
  output logic            ex_illegal
);

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic            funct7_5;
  logic [4:0]      rs1, rs2, rd;
  logic [XLEN-1:0] dec_imm;

  assign opcode   = if_instr[6:0];
  assign rd       = if_instr[11:7];
  assign funct3   = if_instr[14:12];
  assign rs1      = if_instr[19:15];
  assign rs2      = if_instr[24:20];
  assign funct7_5 = if_instr[30];

  assign rf_read_address_1 = rs1;
  assign rf_read_address_2 = rs2;

  imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .instr (if_instr),
    .imm   (dec_imm)
  );

  alu_op_t dec_alu_op;
  logic    dec_src_imm, dec_src_pc, dec_mem_read, dec_mem_write;
  logic    dec_reg_write, dec_branch, dec_jump, dec_illegal;
  logic    rs1_used, rs2_used;

  always_comb begin
    dec_alu_op    = ALU_ADD;
    dec_src_imm   = 1'b0;
    dec_src_pc    = 1'b0;
    dec_mem_read  = 1'b0;
    dec_mem_write = 1'b0;
    dec_reg_write = 1'b0;
    dec_branch    = 1'b0;
    dec_jump      = 1'b0;
    dec_illegal   = 1'b0;
    rs1_used      = 1'b1;
    rs2_used      = 1'b0;
    case (opcode)
      OPC_LUI: begin
        dec_alu_op    = ALU_PASS_B;
        dec_src_imm   = 1'b1;
        dec_reg_write = 1'b1;
        rs1_used      = 1'b0;
      end
      OPC_AUIPC: begin
        dec_src_pc    = 1'b1;
        dec_src_imm   = 1'b1;
        dec_reg_write = 1'b1;
        rs1_used      = 1'b0;
      end
      OPC_JAL: begin
        dec_jump      = 1'b1;
        dec_reg_write = 1'b1;
        rs1_used      = 1'b0;
      end
      OPC_JALR: begin
        dec_jump      = 1'b1;
        dec_reg_write = 1'b1;
        dec_src_imm   = 1'b1;
      end
      OPC_BRANCH: begin
        dec_branch = 1'b1;
        rs2_used   = 1'b1;
        // Compare flavour: EQ/NE subtract, LT/GE signed, LTU/GEU unsigned.
        case (funct3[2:1])
          2'b00:   dec_alu_op = ALU_SUB;
          2'b10:   dec_alu_op = ALU_SLT;
          2'b11:   dec_alu_op = ALU_SLTU;
          default: dec_alu_op = ALU_ADD;
        endcase
      end
      OPC_LOAD: begin
        dec_mem_read  = 1'b1;
        dec_reg_write = 1'b1;
        dec_src_imm   = 1'b1;
      end
      OPC_STORE: begin
        dec_mem_write = 1'b1;
        dec_src_imm   = 1'b1;
        rs2_used      = 1'b1;
      end
      OPC_OP_IMM: begin
        // funct7[5] is part of the immediate for ADDI, so only shifts honour it.
        dec_alu_op    = alu_arith(funct3, (funct3 == F3_SRL_SRA) && funct7_5);
        dec_src_imm   = 1'b1;
        dec_reg_write = 1'b1;
      end
      OPC_OP: begin
        dec_alu_op    = alu_arith(funct3, funct7_5);
        dec_reg_write = 1'b1;
        rs2_used      = 1'b1;
      end
      OPC_FENCE, OPC_SYSTEM: ;
      default: dec_illegal = 1'b1;
    endcase
    if (rd == 5'd0) dec_reg_write = 1'b0;
  end

  logic hazard;
  assign hazard = ex_valid && ex_mem_read && (ex_rd != 5'd0) &&
                  ((rs1_used && (ex_rd == rs1)) || (rs2_used && (ex_rd == rs2)));

  assign id_ready = ~(ex_stall | (hazard & if_valid)) | ex_flush | ~reset;

  always_ff @(posedge clock) begin
    if (!reset) begin
      ex_valid       <= 1'b0;
      ex_pc          <= RESET_PC;
      ex_rs1_data    <= '0;
      ex_rs2_data    <= '0;
      ex_imm         <= '0;
      ex_rs1         <= '0;
      ex_rs2         <= '0;
      ex_rd          <= '0;
      ex_funct3      <= '0;
      ex_alu_op      <= '0;
      ex_alu_src_imm <= 1'b0;
      ex_alu_src_pc  <= 1'b0;
      ex_mem_read    <= 1'b0;
      ex_mem_write   <= 1'b0;
      ex_reg_write   <= 1'b0;
      ex_branch      <= 1'b0;
      ex_jump        <= 1'b0;
      ex_illegal     <= 1'b0;
    end else if (ex_flush) begin
      ex_valid <= 1'b0;
    end else if (ex_stall) begin
      ex_valid <= ex_valid;
    end else if (hazard && if_valid) begin
      ex_valid <= 1'b0;
    end else begin
      ex_valid       <= if_valid;
      ex_pc          <= if_pc;
      ex_rs1_data    <= rf_data_1;
      ex_rs2_data    <= rf_data_2;
      ex_imm         <= dec_imm;
      ex_rs1         <= rs1;
      ex_rs2         <= rs2;
      ex_rd          <= rd;
      ex_funct3      <= funct3;
      ex_alu_op      <= dec_alu_op;
      ex_alu_src_imm <= dec_src_imm;
      ex_alu_src_pc  <= dec_src_pc;
      ex_mem_read    <= dec_mem_read;
      ex_mem_write   <= dec_mem_write;
      ex_reg_write   <= dec_reg_write;
      ex_branch      <= dec_branch;
      ex_jump        <= dec_jump;
      ex_illegal     <= dec_illegal;
    end
  end

endmodule

// File: tb/tb_id_stage.sv
// tb/tb_id_stage.sv - self-checking bench for id_stage
module tb_id_stage;

  localparam logic [31:0] RST_PC = 32'h0000_0100;

  logic        clock = 1'b0;
  logic        reset;
  logic        if_valid;
  logic [31:0] if_instr, if_pc;
  logic        id_ready;
  logic [4:0]  rf_read_address_1, rf_read_address_2;
  logic [31:0] rf_data_1, rf_data_2;
  logic        ex_stall, ex_flush;
  logic        ex_valid;
  logic [31:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
  logic [4:0]  ex_rs1, ex_rs2, ex_rd;
  logic [2:0]  ex_funct3;
  logic [3:0]  ex_alu_op;
  logic        ex_alu_src_imm, ex_alu_src_pc, ex_mem_read, ex_mem_write;
  logic        ex_reg_write, ex_branch, ex_jump, ex_illegal;

  int cmp_cnt = 0;
  int err_cnt = 0;

  always #5 clock = ~clock;

  id_stage #(.XLEN(32), .RESET_PC(RST_PC)) dut (
    .clock(clock), .reset(reset), .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
    .id_ready(id_ready), .rf_read_address_1(rf_read_address_1),
    .rf_read_address_2(rf_read_address_2), .rf_data_1(rf_data_1), .rf_data_2(rf_data_2),
    .ex_stall(ex_stall), .ex_flush(ex_flush), .ex_valid(ex_valid), .ex_pc(ex_pc),
    .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_funct3(ex_funct3),
    .ex_alu_op(ex_alu_op), .ex_alu_src_imm(ex_alu_src_imm), .ex_alu_src_pc(ex_alu_src_pc),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_reg_write(ex_reg_write),
    .ex_branch(ex_branch), .ex_jump(ex_jump), .ex_illegal(ex_illegal)
  );

  typedef struct packed {
    logic        valid;
    logic [31:0] pc, d1, d2, imm;
    logic [4:0]  rs1, rs2, rd;
    logic [2:0]  f3;
    logic [3:0]  alu;
    logic        src_imm, src_pc, mrd, mwr, rwr, br, jmp, ill;
  } ex_t;

  // Reference state of the ID/EX register; exp_full=0 means only valid is defined.
  ex_t  exp_q;
  logic exp_full;

  function automatic ex_t dut_ex();
    ex_t r;
    r = {ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm, ex_rs1, ex_rs2, ex_rd,
         ex_funct3, ex_alu_op, ex_alu_src_imm, ex_alu_src_pc, ex_mem_read, ex_mem_write,
         ex_reg_write, ex_branch, ex_jump, ex_illegal};
    return r;
  endfunction

  // ALU codes by name: ADD 0 SUB 1 SLL 2 SLT 3 SLTU 4 XOR 5 SRL 6 SRA 7 OR 8 AND 9 PASS_B 10
  function automatic logic [3:0] arith_op(logic [2:0] f3, logic alt);
    logic [3:0] tbl [8];
    tbl = '{4'd0, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9};
    if (alt && f3 == 3'd0) return 4'd1;
    if (alt && f3 == 3'd5) return 4'd7;
    return tbl[f3];
  endfunction

  function automatic ex_t model_decode(logic [31:0] ins, logic [31:0] pc, logic [31:0] d1,
                                       logic [31:0] d2);
    ex_t r;
    int  i_imm, s_imm, b_imm, j_imm;
    i_imm = $signed(ins[31:20]);
    s_imm = $signed({ins[31:25], ins[11:7]});
    b_imm = $signed({ins[31], ins[7], ins[30:25], ins[11:8]}) * 2;
    j_imm = $signed({ins[31], ins[19:12], ins[20], ins[30:21]}) * 2;
    r = '0;
    r.pc = pc; r.d1 = d1; r.d2 = d2;
    r.rs1 = ins[19:15]; r.rs2 = ins[24:20]; r.rd = ins[11:7]; r.f3 = ins[14:12];
    case (ins[6:0])
      7'h37: begin r.imm = ins & 32'hFFFF_F000; r.alu = 4'd10; r.src_imm = 1; r.rwr = 1; end
      7'h17: begin r.imm = ins & 32'hFFFF_F000; r.src_pc = 1; r.src_imm = 1; r.rwr = 1; end
      7'h6F: begin r.imm = j_imm; r.jmp = 1; r.rwr = 1; end
      7'h67: begin r.imm = i_imm; r.jmp = 1; r.rwr = 1; r.src_imm = 1; end
      7'h63: begin
        r.imm = b_imm; r.br = 1;
        if (r.f3 <= 3'd1) r.alu = 4'd1;
        else if (r.f3 >= 3'd6) r.alu = 4'd4;
        else if (r.f3 >= 3'd4) r.alu = 4'd3;
      end
      7'h03: begin r.imm = i_imm; r.mrd = 1; r.rwr = 1; r.src_imm = 1; end
      7'h23: begin r.imm = s_imm; r.mwr = 1; r.src_imm = 1; end
      7'h13: begin r.imm = i_imm; r.rwr = 1; r.src_imm = 1; r.alu = arith_op(r.f3, r.f3 == 3'd5 && ins[30]); end
      7'h33: begin r.rwr = 1; r.alu = arith_op(r.f3, ins[30]); end
      7'h0F, 7'h73: ;
      default: r.ill = 1;
    endcase
    if (r.rd == 5'd0) r.rwr = 0;
    return r;
  endfunction

  function automatic logic model_hazard();
    logic [6:0] op;
    logic reads1, reads2;
    op = if_instr[6:0];
    reads1 = !(op == 7'h37 || op == 7'h17 || op == 7'h6F);
    reads2 = (op == 7'h63 || op == 7'h23 || op == 7'h33);
    return exp_q.valid && exp_q.mrd && exp_q.rd != 0 &&
           ((reads1 && exp_q.rd == if_instr[19:15]) || (reads2 && exp_q.rd == if_instr[24:20]));
  endfunction

  function automatic logic model_ready();
    return !reset || ex_flush || !(ex_stall || (model_hazard() && if_valid));
  endfunction

  // Applies the ID/EX update priority to the reference state, then clocks.
  task automatic tick();
    ex_t d;
    d = model_decode(if_instr, if_pc, rf_data_1, rf_data_2);
    if (!reset) begin
      exp_q = '0; exp_q.pc = RST_PC; exp_full = 1;
    end else if (ex_flush) begin
      exp_q.valid = 0; exp_full = 0;
    end else if (ex_stall) begin
    end else if (model_hazard() && if_valid) begin
      exp_q.valid = 0; exp_full = 0;
    end else begin
      exp_q = d; exp_q.valid = if_valid; exp_full = 1;
    end
    @(posedge clock);
    #1;
  endtask

  task automatic drive(logic [31:0] ins, logic v, logic st, logic fl);
    if_instr  = ins;
    if_valid  = v;
    ex_stall  = st;
    ex_flush  = fl;
    if_pc     = $urandom & 32'hFFFF_FFFC;
    rf_data_1 = $urandom;
    rf_data_2 = $urandom;
    #1;
  endtask

  task automatic test_reset();
    reset = 0;
    drive(32'h0050_0093, 1, 1, 0);
    cmp_cnt++;
    if (id_ready !== 1'b1) begin err_cnt++; $display("FAIL reset_ready got %b want 1", id_ready); end
    tick();
    tick();
    cmp_cnt++;
    if (dut_ex() !== exp_q || ex_pc !== RST_PC || ex_valid !== 1'b0) begin
      err_cnt++; $display("FAIL reset_state got %h want %h", dut_ex(), exp_q);
    end
    reset = 1;
  endtask

  task automatic test_addi();
    drive(32'h0050_0093, 1, 0, 0);
    cmp_cnt++;
    if ({rf_read_address_1, rf_read_address_2} !== {5'd0, 5'd5}) begin
      err_cnt++; $display("FAIL addi_rf_addr got %0d/%0d want 0/5", rf_read_address_1, rf_read_address_2);
    end
    tick();
    cmp_cnt++;
    if ({ex_valid, ex_rd, ex_imm, ex_alu_op, ex_alu_src_imm, ex_reg_write} !==
        {1'b1, 5'd1, 32'd5, 4'd0, 1'b1, 1'b1}) begin
      err_cnt++; $display("FAIL addi got v=%b rd=%0d imm=%h alu=%0d", ex_valid, ex_rd, ex_imm, ex_alu_op);
    end
  endtask

  task automatic test_load_use();
    drive(32'h0000_A103, 1, 0, 0);
    tick();
    drive(32'h0011_01B3, 1, 0, 0);
    cmp_cnt++;
    if (id_ready !== 1'b0) begin err_cnt++; $display("FAIL lu_ready_low got %b want 0", id_ready); end
    tick();
    cmp_cnt++;
    if (ex_valid !== 1'b0) begin err_cnt++; $display("FAIL lu_bubble got %b want 0", ex_valid); end
    drive(32'h0011_01B3, 1, 0, 0);
    cmp_cnt++;
    if (id_ready !== 1'b1) begin err_cnt++; $display("FAIL lu_ready_back got %b want 1", id_ready); end
    tick();
    cmp_cnt++;
    if ({ex_valid, ex_rs1, ex_rs2, ex_rd} !== {1'b1, 5'd2, 5'd1, 5'd3}) begin
      err_cnt++; $display("FAIL lu_add got v=%b rs1=%0d rs2=%0d rd=%0d", ex_valid, ex_rs1, ex_rs2, ex_rd);
    end
  endtask

  task automatic test_store_branch_lui_illegal();
    drive(32'h0020_A423, 1, 0, 0);
    tick();
    cmp_cnt++;
    if ({ex_imm, ex_mem_write, ex_reg_write} !== {32'd8, 1'b1, 1'b0}) begin
      err_cnt++; $display("FAIL sw got imm=%h mw=%b rw=%b", ex_imm, ex_mem_write, ex_reg_write);
    end
    drive(32'hFE20_8EE3, 1, 0, 0);
    tick();
    cmp_cnt++;
    if ({ex_imm, ex_branch, ex_reg_write} !== {32'hFFFF_FFFC, 1'b1, 1'b0}) begin
      err_cnt++; $display("FAIL beq got imm=%h br=%b", ex_imm, ex_branch);
    end
    drive(32'h1234_52B7, 1, 0, 0);
    tick();
    cmp_cnt++;
    if ({ex_imm, ex_alu_op, ex_alu_src_imm, ex_reg_write} !== {32'h1234_5000, 4'd10, 1'b1, 1'b1}) begin
      err_cnt++; $display("FAIL lui got imm=%h alu=%0d", ex_imm, ex_alu_op);
    end
    drive(32'h0000_00FF, 1, 0, 0);
    tick();
    cmp_cnt++;
    if ({ex_valid, ex_illegal, ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_jump} !==
        7'b1100000) begin
      err_cnt++; $display("FAIL illegal got v=%b ill=%b rw=%b mr=%b mw=%b br=%b j=%b", ex_valid,
                          ex_illegal, ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_jump);
    end
  endtask

  task automatic test_stall_flush();
    ex_t snap;
    drive(32'h0050_0093, 1, 0, 0);
    tick();
    snap = exp_q;
    for (int i = 0; i < 3; i++) begin
      drive(32'h1234_52B7, 1, 1, 0);
      cmp_cnt++;
      if (id_ready !== 1'b0) begin err_cnt++; $display("FAIL stall_ready[%0d] got %b want 0", i, id_ready); end
      tick();
      cmp_cnt++;
      if (dut_ex() !== snap) begin err_cnt++; $display("FAIL stall_hold[%0d] got %h want %h", i, dut_ex(), snap); end
    end
    drive(32'h1234_52B7, 1, 1, 1);
    cmp_cnt++;
    if (id_ready !== 1'b1) begin err_cnt++; $display("FAIL flush_ready got %b want 1", id_ready); end
    tick();
    cmp_cnt++;
    if (ex_valid !== 1'b0) begin err_cnt++; $display("FAIL flush_stall got %b want 0", ex_valid); end
  endtask

  task automatic test_flush_over_hazard();
    drive(32'h0000_A103, 1, 0, 0);
    tick();
    drive(32'h0011_01B3, 1, 0, 1);
    cmp_cnt++;
    if (id_ready !== 1'b1) begin err_cnt++; $display("FAIL flush_haz_ready got %b want 1", id_ready); end
    tick();
    cmp_cnt++;
    if (ex_valid !== 1'b0) begin err_cnt++; $display("FAIL flush_haz_valid got %b want 0", ex_valid); end
  endtask

  task automatic test_reset_mid_stall();
    drive(32'h0000_A103, 1, 0, 0);
    tick();
    drive(32'h0011_01B3, 1, 1, 0);
    reset = 0;
    #1;
    cmp_cnt++;
    if (id_ready !== 1'b1) begin err_cnt++; $display("FAIL rst_stall_ready got %b want 1", id_ready); end
    tick();
    reset = 1;
    cmp_cnt++;
    if (ex_valid !== 1'b0 || ex_pc !== RST_PC || dut_ex() !== exp_q) begin
      err_cnt++; $display("FAIL rst_mid_stall got %h want %h", dut_ex(), exp_q);
    end
  endtask

  task automatic test_random();
    logic [6:0]  ops [12];
    logic [31:0] ins;
    logic        held;
    ops = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h0F, 7'h73, 7'h7F};
    held = 0;
    ins  = 32'h0000_0013;
    for (int n = 0; n < 400; n++) begin
      if (!held) begin
        ins = $urandom;
        ins[6:0]   = ops[$urandom_range(0, 11)];
        ins[11:7]  = 5'($urandom_range(0, 3));
        ins[19:15] = 5'($urandom_range(0, 3));
        ins[24:20] = 5'($urandom_range(0, 3));
      end
      reset = ($urandom_range(0, 49) != 0);
      drive(ins, $urandom_range(0, 7) != 0, $urandom_range(0, 5) == 0, $urandom_range(0, 9) == 0);
      cmp_cnt++;
      if (id_ready !== model_ready()) begin
        err_cnt++; $display("FAIL rand_ready[%0d] got %b want %b", n, id_ready, model_ready());
      end
      held = reset && !model_ready();
      tick();
      cmp_cnt++;
      if (exp_full ? (dut_ex() !== exp_q) : (ex_valid !== exp_q.valid)) begin
        err_cnt++; $display("FAIL rand_ex[%0d] got %h want %h", n, dut_ex(), exp_q);
      end
    end
    reset = 1;
  endtask

  initial begin
    exp_q = '0;
    exp_full = 0;
    reset = 0;
    if_valid = 0; if_instr = 0; if_pc = 0; ex_stall = 0; ex_flush = 0;
    rf_data_1 = 0; rf_data_2 = 0;
    @(posedge clock);
    #1;
    test_reset();
    test_addi();
    test_load_use();
    test_store_branch_lui_illegal();
    test_stall_flush();
    test_flush_over_hazard();
    test_reset_mid_stall();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
